// File: rtl/serial_receiver.sv
// Serial frame receiver: rebuilds LSB-first words from a valid-qualified bit stream,
// flags underrun/overrun frames and drives two active-low hex digits from the last good word.
module serial_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serIn,
    input  logic             serInValid,
    output logic [WIDTH-1:0] dataOut,
    output logic             dataValid,
    output logic             frameErr,
    output logic             errSticky,
    output logic [3:0]       frameCnt,
    output logic [6:0]       seg0,
    output logic [6:0]       seg1
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [3:0]       fcnt_q, fcnt_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        sticky_d = sticky_q;
        fcnt_d   = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                // Stale shift contents need no clearing: a full frame pushes all of them out.
                if (serInValid) begin
                    shift_d = {serIn, shift_q[WIDTH-1:1]};
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (serInValid) begin
                    if (cnt_q < CNT_FULL) begin
                        shift_d = {serIn, shift_q[WIDTH-1:1]};
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_DRAIN;
                    end
                end else begin
                    if (cnt_q == CNT_FULL) begin
                        data_d   = shift_q;
                        valid_d  = 1'b1;
                        fcnt_d   = fcnt_q + 4'd1;
                        sticky_d = 1'b0;
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!serInValid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            fcnt_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign dataOut   = data_q;
    assign dataValid = valid_q;
    assign frameErr  = err_q;
    assign errSticky = sticky_q;
    assign frameCnt  = fcnt_q;
    assign seg0      = hex7(data_q[3:0]);
    assign seg1      = hex7(data_q[7:4]);

endmodule
